// File: rtl/tdm_rx.sv
// TDM slot receiver: detects frame starts on wclk, deserialises SLOTS words of
// SLOT_W bits after DELAY bclk edges, supervises the frame interval and reports lock.
module tdm_rx #(
    parameter int  SLOT_W      = 32,
    parameter int  SLOTS       = 2,
    parameter int  DELAY       = 1,
    parameter int  FRAME_BCLKS = 64,
    localparam int IDX_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              bclk,
    input  logic              rst_n,
    input  logic              wclk,
    input  logic              tdm_in,
    output logic [SLOT_W-1:0] slot_data,
    output logic [IDX_W-1:0]  slot_idx,
    output logic              slot_valid,
    output logic              frame_err,
    output logic              locked
);

    localparam int BIT_W = $clog2(SLOT_W);
    localparam int INT_W = ($clog2(FRAME_BCLKS + 2) > 7) ? $clog2(FRAME_BCLKS + 2) : 7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RECV
    } state_e;

    state_e            state_q;
    logic [1:0]        wc_ff;
    logic [1:0]        wc_vld_q;
    logic [2:0]        dly_q;
    logic [BIT_W-1:0]  bit_q;
    logic [IDX_W-1:0]  slot_q;
    logic [SLOT_W-1:0] shift_q;
    logic [INT_W-1:0]  intv_q;
    logic              seen_fs_q;
    logic [1:0]        good_q;

    logic              fs;
    logic              last_bit;
    logic              last_slot;
    logic              abort;
    logic              slot_done;
    logic              err_d;
    logic [SLOT_W-1:0] word_d;

    // Both wclk history bits must be real post-reset samples, so a wclk that is
    // already high when reset releases is not mistaken for a fresh frame start.
    assign fs        = (wc_ff == 2'b01) && wc_vld_q[1];
    assign last_bit  = (state_q == RECV) && (bit_q == BIT_W'(SLOT_W - 1));
    assign last_slot = (slot_q == IDX_W'(SLOTS - 1));
    assign abort     = fs && (state_q != IDLE) && !(last_bit && last_slot);
    assign slot_done = last_bit && !abort;
    assign err_d     = fs && (abort || (seen_fs_q && (intv_q != INT_W'(FRAME_BCLKS))));
    assign word_d    = {shift_q[SLOT_W-2:0], tdm_in};

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wc_ff      <= 2'b00;
            wc_vld_q   <= 2'b00;
            dly_q      <= '0;
            bit_q      <= '0;
            slot_q     <= '0;
            shift_q    <= '0;
            intv_q     <= '0;
            seen_fs_q  <= 1'b0;
            good_q     <= 2'd0;
            slot_data  <= '0;
            slot_idx   <= '0;
            slot_valid <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            wc_ff      <= {wc_ff[0], wclk};
            wc_vld_q   <= {wc_vld_q[0], 1'b1};
            slot_valid <= 1'b0;
            frame_err  <= err_d;

            if (fs) begin
                intv_q    <= INT_W'(1);
                seen_fs_q <= 1'b1;
            end else if (intv_q != '1) begin
                intv_q <= intv_q + 1'b1;
            end

            // Lock needs two good intervals in a row; any error drops it at once.
            if (err_d) begin
                good_q <= 2'd0;
                locked <= 1'b0;
            end else if (fs && seen_fs_q) begin
                if (good_q != 2'd2) good_q <= good_q + 2'd1;
                if (good_q != 2'd0) locked <= 1'b1;
            end

            if (slot_done) begin
                slot_data  <= word_d;
                slot_idx   <= slot_q;
                slot_valid <= 1'b1;
            end

            case (state_q)
                IDLE: ;
                WAIT: begin
                    if (dly_q == 3'(DELAY)) begin
                        shift_q <= word_d;
                        bit_q   <= BIT_W'(1);
                        state_q <= RECV;
                    end else begin
                        dly_q <= dly_q + 3'd1;
                    end
                end
                RECV: begin
                    shift_q <= word_d;
                    if (last_bit) begin
                        bit_q <= '0;
                        if (last_slot) begin
                            slot_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // NOTE: with non-blocking assignments the last one in the block wins,
            // so a frame start here overrides whatever the case statement chose.
            if (fs) begin
                state_q <= WAIT;
                dly_q   <= 3'd1;
                bit_q   <= '0;
                slot_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_rx.sv
// Self-checking bench for tdm_rx: per-scenario stimulus tables with random data,
// compared every bclk edge against an event-level model of the frame rules.
module tb_tdm_rx;

    localparam int SLOT_W      = 32;
    localparam int SLOTS       = 2;
    localparam int DELAY       = 1;
    localparam int FRAME_BCLKS = 64;
    localparam int IDX_W       = 1;
    localparam int FRAME_END   = DELAY + SLOTS * SLOT_W - 1;
    localparam int N           = 1100;

    logic              bclk   = 1'b0;
    logic              rst_n  = 1'b0;
    logic              wclk   = 1'b0;
    logic              tdm_in = 1'b0;
    logic [SLOT_W-1:0] slot_data;
    logic [IDX_W-1:0]  slot_idx;
    logic              slot_valid;
    logic              frame_err;
    logic              locked;

    tdm_rx #(
        .SLOT_W     (SLOT_W),
        .SLOTS      (SLOTS),
        .DELAY      (DELAY),
        .FRAME_BCLKS(FRAME_BCLKS)
    ) dut (
        .bclk      (bclk),
        .rst_n     (rst_n),
        .wclk      (wclk),
        .tdm_in    (tdm_in),
        .slot_data (slot_data),
        .slot_idx  (slot_idx),
        .slot_valid(slot_valid),
        .frame_err (frame_err),
        .locked    (locked)
    );

    always #5 bclk = ~bclk;

    // Stimulus per cycle k: driven on the falling edge, sampled at rising edge k.
    bit                rst_a [N];
    bit                wclk_a[N];
    bit                tdm_a [N];
    // Expected outputs just after rising edge k.
    bit                ev [N];
    bit                ee [N];
    bit                el [N];
    logic [SLOT_W-1:0] evd[N];
    logic [IDX_W-1:0]  evi[N];
    logic [SLOT_W-1:0] ed [N];
    logic [IDX_W-1:0]  ei [N];

    int rises[$];
    int seg_len;
    int n_run   = 0;
    int n_fail  = 0;
    int err_cnt = 0;

    task automatic init_seg(input int len, input int nrst);
        seg_len = len;
        rises.delete();
        for (int k = 0; k < N; k++) begin
            rst_a[k]  = (k >= nrst);
            wclk_a[k] = 1'b0;
            tdm_a[k]  = 1'($urandom_range(0, 1));
        end
    endtask

    // wclk is high for half the interval to the next rise (at most 32 cycles).
    task automatic make_wclk();
        for (int j = 0; j < rises.size(); j++) begin
            int hi;
            hi = 32;
            if (j + 1 < rises.size() && (rises[j+1] - rises[j]) / 2 < hi)
                hi = (rises[j+1] - rises[j]) / 2;
            for (int k = rises[j]; k < rises[j] + hi && k < seg_len; k++) wclk_a[k] = 1'b1;
        end
    endtask

    task automatic put_word(input int e_fs, input int s, input logic [SLOT_W-1:0] w);
        for (int i = 0; i < SLOT_W; i++) begin
            int idx;
            idx = e_fs + DELAY + s * SLOT_W + i;
            if (idx < N) tdm_a[idx] = w[SLOT_W-1-i];
        end
    endtask

    function automatic logic [SLOT_W-1:0] word_at(input int c);
        logic [SLOT_W-1:0] w;
        w = '0;
        for (int i = 0; i < SLOT_W; i++) w = {w[SLOT_W-2:0], tdm_a[c - SLOT_W + 1 + i]};
        return w;
    endfunction

    // Event-level model: find frame starts per reset epoch, then derive slot
    // completions, interval/abort errors and lock from the frame-start list.
    task automatic build_model();
        int fs[$];
        int e0, e1, good;
        bit lk, bad, ok;
        logic [SLOT_W-1:0] hd;
        logic [IDX_W-1:0]  hi;
        for (int k = 0; k < N; k++) begin
            ev[k] = 0; ee[k] = 0; el[k] = 0; evd[k] = '0; evi[k] = '0;
        end
        e0 = 0;
        while (e0 < seg_len) begin
            while (e0 < seg_len && !rst_a[e0]) e0++;
            e1 = e0;
            while (e1 < seg_len && rst_a[e1]) e1++;
            fs.delete();
            for (int e = e0 + 2; e < e1; e++)
                if (!wclk_a[e-2] && wclk_a[e-1]) fs.push_back(e);
            good = 0;
            lk   = 0;
            for (int j = 0; j < fs.size(); j++) begin
                int nxt;
                if (j > 0) begin
                    bad = (fs[j] - fs[j-1] != FRAME_BCLKS) || (fs[j] < fs[j-1] + FRAME_END);
                    if (bad) begin
                        ee[fs[j]] = 1;
                        good = 0;
                        lk   = 0;
                    end else begin
                        good++;
                        if (good >= 2) lk = 1;
                    end
                end
                nxt = (j + 1 < fs.size()) ? fs[j+1] : e1;
                for (int e = fs[j]; e < nxt; e++) el[e] = lk;
                for (int s = 0; s < SLOTS; s++) begin
                    int c;
                    c  = fs[j] + DELAY + (s + 1) * SLOT_W - 1;
                    ok = (c < e1) && ((j + 1 >= fs.size()) || (c < fs[j+1]) ||
                                      (c == fs[j+1] && s == SLOTS - 1));
                    if (ok) begin
                        ev[c]  = 1;
                        evd[c] = word_at(c);
                        evi[c] = IDX_W'(s);
                    end
                end
            end
            e0 = e1;
        end
        hd = '0;
        hi = '0;
        for (int k = 0; k < N; k++) begin
            if (!rst_a[k]) begin
                hd = '0;
                hi = '0;
            end else if (ev[k]) begin
                hd = evd[k];
                hi = evi[k];
            end
            ed[k] = hd;
            ei[k] = hi;
        end
    endtask

    task automatic step(input int k);
        @(negedge bclk);
        rst_n  = rst_a[k];
        wclk   = wclk_a[k];
        tdm_in = tdm_a[k];
        @(posedge bclk);
        #1;
        if (frame_err) err_cnt++;
    endtask

    task automatic test_reset();
        init_seg(90, 5);
        build_model();
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL reset_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
            n_run++;
            if (k < 5 && {slot_valid, frame_err, locked, slot_idx, slot_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_zero edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want all 0",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data);
            end else if (k >= 5 && slot_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_valid edge %0d: got slot_valid=%b, want 0", k, slot_valid);
            end
        end
    endtask

    task automatic test_nominal();
        int e;
        init_seg(260, 3);
        for (int j = 0; j < 4; j++) rises.push_back(10 + 64 * j);
        make_wclk();
        e = rises[0] + 1;
        put_word(e, 0, 32'hABCD0000);
        put_word(e, 1, 32'h12345678);
        build_model();
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL nominal_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
            if (k == e + 32) begin
                n_run++;
                if ({slot_valid, slot_idx, slot_data} !== {1'b1, 1'b0, 32'hABCD0000}) begin
                    n_fail++;
                    $display("FAIL nominal_slot0: got v=%b idx=%0d data=%h, want v=1 idx=0 data=abcd0000",
                             slot_valid, slot_idx, slot_data);
                end
            end
            if (k == e + 64) begin
                n_run++;
                if ({slot_valid, slot_idx, slot_data} !== {1'b1, 1'b1, 32'h12345678}) begin
                    n_fail++;
                    $display("FAIL nominal_slot1: got v=%b idx=%0d data=%h, want v=1 idx=1 data=12345678",
                             slot_valid, slot_idx, slot_data);
                end
            end
        end
    endtask

    task automatic test_lock();
        init_seg(420, 3);
        for (int j = 0; j < 5; j++) rises.push_back(10 + 64 * j);
        make_wclk();
        build_model();
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL lock_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
            for (int j = 0; j < 5; j++) begin
                if (k == rises[j] + 1) begin
                    n_run++;
                    if (locked !== (j >= 2)) begin
                        n_fail++;
                        $display("FAIL lock_at_fs%0d: got locked=%b, want %b", j + 1, locked, j >= 2);
                    end
                end
            end
        end
        n_run++;
        if (err_cnt != 0) begin
            n_fail++;
            $display("FAIL lock_no_err: got %0d frame_err pulses, want 0", err_cnt);
        end
    endtask

    task automatic test_early_sync();
        int f_ab, f_early;
        init_seg(520, 3);
        for (int j = 0; j < 4; j++) rises.push_back(10 + 64 * j);
        rises.push_back(202 + 40);
        for (int j = 1; j <= 3; j++) rises.push_back(242 + 64 * j);
        make_wclk();
        build_model();
        f_ab    = 202 + 1;
        f_early = 242 + 1;
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL early_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
            if (k == f_early - 1 || k == f_early) begin
                n_run++;
                if ({frame_err, locked} !== ((k == f_early) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL early_err_lock edge %0d: got err=%b locked=%b, want %b",
                             k, frame_err, locked, (k == f_early) ? 2'b10 : 2'b01);
                end
            end
            if (k == f_ab + FRAME_END) begin
                n_run++;
                if (slot_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_no_slot1: got slot_valid=%b, want 0", slot_valid);
                end
            end
        end
        n_run++;
        if (err_cnt != 1) begin
            n_fail++;
            $display("FAIL early_err_count: got %0d frame_err pulses, want 1", err_cnt);
        end
    endtask

    task automatic test_missing_sync();
        int f_last, f_gap;
        init_seg(480, 3);
        rises.push_back(10);
        rises.push_back(74);
        rises.push_back(138);
        rises.push_back(266);
        rises.push_back(330);
        rises.push_back(394);
        make_wclk();
        build_model();
        f_last  = 139;
        f_gap   = 267;
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL missing_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
            if (k > f_last + FRAME_END && k < f_gap) begin
                n_run++;
                if (slot_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL missing_idle edge %0d: got slot_valid=%b, want 0", k, slot_valid);
                end
            end
            if (k == f_gap) begin
                n_run++;
                if (frame_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL missing_err: got frame_err=%b, want 1", frame_err);
                end
            end
        end
        n_run++;
        if (err_cnt != 1) begin
            n_fail++;
            $display("FAIL missing_err_count: got %0d frame_err pulses, want 1", err_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int r_edge;
        init_seg(330, 3);
        for (int j = 0; j < 4; j++) rises.push_back(10 + 64 * j);
        make_wclk();
        r_edge = rises[0] + 1 + DELAY + 20;
        rst_a[r_edge] = 1'b0;
        build_model();
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL midrst_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
            if (k == r_edge) begin
                n_run++;
                if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== '0) begin
                    n_fail++;
                    $display("FAIL midrst_zero: got v=%b e=%b l=%b idx=%0d data=%h, want all 0",
                             slot_valid, frame_err, locked, slot_idx, slot_data);
                end
            end
        end
        n_run++;
        if (err_cnt != 0) begin
            n_fail++;
            $display("FAIL midrst_no_err: got %0d frame_err pulses, want 0", err_cnt);
        end
    endtask

    task automatic test_random();
        int r, iv;
        init_seg(1000, 3);
        r = 10;
        while (r < seg_len - 150) begin
            rises.push_back(r);
            iv = FRAME_BCLKS;
            if ($urandom_range(0, 3) == 0) begin
                do iv = int'($urandom_range(20, 140)); while (iv == DELAY + SLOT_W - 1);
            end
            r += iv;
        end
        make_wclk();
        build_model();
        err_cnt = 0;
        for (int k = 0; k < seg_len; k++) begin
            step(k);
            n_run++;
            if ({slot_valid, frame_err, locked, slot_idx, slot_data} !== {ev[k], ee[k], el[k], ei[k], ed[k]}) begin
                n_fail++;
                $display("FAIL random_model edge %0d: got v=%b e=%b l=%b idx=%0d data=%h, want v=%b e=%b l=%b idx=%0d data=%h",
                         k, slot_valid, frame_err, locked, slot_idx, slot_data, ev[k], ee[k], el[k], ei[k], ed[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock();
        test_early_sync();
        test_missing_sync();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_rx.md
TDM_RX -- requirements
Module: tdm_rx

Interface
REQ-001 Parameter SLOT_W, default 32, bits per TDM slot.
REQ-002 Parameter SLOTS, default 2, slots per frame.
REQ-003 Parameter DELAY, default 1, bclk rising edges from the frame-start detection edge to the slot-0 MSB sample, range 1..7.
REQ-004 Parameter FRAME_BCLKS, default 64, nominal bclk count between frame starts, at least SLOTS*SLOT_W.
REQ-005 bclk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wclk  input  1  frame sync; a rising edge marks a frame start; asynchronous to internal state.
REQ-008 tdm_in  input  1  serial TDM data, MSB first; upstream changes it on the falling edge of bclk.
REQ-009 slot_data  output  SLOT_W  last completed slot word.
REQ-010 slot_idx  output  clog2(SLOTS) (min 1)  index of slot_data within the frame.
REQ-011 slot_valid  output  1  one-cycle pulse; slot_data and slot_idx are new.
REQ-012 frame_err  output  1  one-cycle pulse on a frame-timing violation.
REQ-013 locked  output  1  level; frame timing is stable.

Function
REQ-014 wclk SHALL pass through a 2-flop shift register wc_ff on bclk rising edges; a frame start (fs) is an edge at which pre-update wc_ff == 2'b01.
REQ-015 tdm_in SHALL be sampled only on bclk rising edges.
REQ-016 FSM states: IDLE, WAIT, RECV.
- IDLE: fs -> WAIT with delay counter = 1.
- WAIT: counts edges; the edge DELAY after fs is the first RECV sample (slot 0, MSB).
- RECV: shifts one bit per edge into a SLOT_W shift register.
REQ-017 In RECV, the edge that samples bit SLOT_W-1 of a slot SHALL do three things:
- load slot_data with the full word;
- set slot_idx to the slot number;
- pulse slot_valid for exactly one cycle.
REQ-018 After the last bit of slot SLOTS-1 the FSM SHALL return to IDLE; outputs hold until the next slot completes.
REQ-019 Interval counter: 7 bits minimum, cleared to 1 on each fs, incremented each edge, saturating at all-ones.
REQ-020 Interval check at each fs after the first since reset:
- interval == FRAME_BCLKS: good interval.
- interval != FRAME_BCLKS: frame_err pulse.
REQ-021 locked SHALL assert on the second consecutive good interval and clear on the same edge as any frame_err.
REQ-022 fs while in RECV or WAIT before the final bit of the frame SHALL:
- pulse frame_err;
- discard the partial slot, with no slot_valid for it;
- restart in WAIT.
REQ-023 fs on the same edge as the final bit of the frame SHALL:
- complete that slot normally (slot_valid pulses);
- enter WAIT for the new frame;
- raise no error from this coincidence alone.
REQ-024 The first fs after reset SHALL never pulse frame_err.
REQ-025 The slot counter and bit counter SHALL reset to 0 on every frame restart.

Reset
REQ-026 While rst_n is low, these SHALL be 0: slot_data, slot_idx, slot_valid, frame_err, locked, wc_ff, and all counters; the FSM SHALL be in IDLE.
REQ-027 When rst_n deasserts mid-frame, the block SHALL stay idle until a fresh wclk rising edge is detected; no partial slot is emitted.

Verification
REQ-028 Reset: hold rst_n low for 5 bclk with tdm_in toggling -> all outputs 0; after release, no slot_valid without a wclk rise.
REQ-029 Nominal case, defaults, fs at edge E, bits driven on falling edges:
- stimulus: slot 0 = 0xABCD0000, slot 1 = 0x12345678.
- after edge E+32: slot_valid=1, slot_idx=0, slot_data=0xABCD0000.
- after edge E+64: slot_valid=1, slot_idx=1, slot_data=0x12345678.
REQ-030 Lock: wclk period exactly 64 bclk for 4 frames -> locked=1 from the third fs onward; frame_err never pulses.
REQ-031 Early sync: locked, then wclk rises 40 bclk after the previous rise ->
- frame_err pulses once and locked drops to 0;
- no slot_valid for slot 1 of the aborted frame;
- the next frame decodes correctly.
REQ-032 Missing sync: skip one wclk rise ->
- after 64 bits the FSM idles with no further slot_valid;
- the next fs (interval 128) pulses frame_err; the following frame decodes.
REQ-033 Mid-frame reset: assert rst_n for 1 cycle at bit 20 of slot 0 -> all outputs 0; the next frame decodes correctly, with no frame_err on its fs.
